int_scheduler: RTL and testbench

INT_SCHEDULER -- requirements
Module: int_scheduler

---
 rtl/int_scheduler.sv | 120 ++++++++++++
 tb/tb_int_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/int_scheduler.sv
// Round-robin interrupt scheduler: latches 16 interrupt sources and grants one at a
// time. A grant is released by an acknowledge or, optionally, by a hold timeout.
module int_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] irq_in,
    input  logic [15:0] mask,
    input  logic        int_ack,
    output logic        int_valid,
    output logic [3:0]  int_id,
    output logic [15:0] int_onehot,
    output logic [15:0] pending,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [3:0]      ptr, ptr_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [15:0]     pending_nx, clr;
    logic            valid_nx, terr_nx;
    logic [3:0]      id_nx;
    logic [15:0]     onehot_nx;

    logic [15:0]     eligible;
    logic            found;
    logic [3:0]      sel, idx;

    assign eligible = pending & mask;

    // Rotating priority search starting at ptr, wrapping 15 -> 0.
    always_comb begin
        found = 1'b0;
        sel   = 4'd0;
        idx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            idx = ptr + 4'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        cnt_nx    = cnt;
        clr       = 16'd0;
        valid_nx  = int_valid;
        id_nx     = int_id;
        onehot_nx = int_onehot;
        terr_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx  = GRANT;
                    valid_nx  = 1'b1;
                    id_nx     = sel;
                    onehot_nx = 16'd1 << sel;
                    cnt_nx    = '0;
                end else begin
                    valid_nx  = 1'b0;
                    onehot_nx = 16'd0;
                end
            end
            GRANT: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (int_ack) begin
                    clr       = int_onehot;
                    ptr_nx    = int_id + 4'd1;
                    state_nx  = IDLE;
                    valid_nx  = 1'b0;
                    onehot_nx = 16'd0;
                    cnt_nx    = '0;
                end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
                    ptr_nx    = int_id + 4'd1;
                    state_nx  = IDLE;
                    valid_nx  = 1'b0;
                    onehot_nx = 16'd0;
                    terr_nx   = 1'b1;
                    cnt_nx    = '0;
                end else begin
                    cnt_nx    = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // New events take priority over the acknowledge clear.
        pending_nx = (pending & ~clr) | irq_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= 4'd0;
            cnt         <= '0;
            pending     <= 16'd0;
            int_valid   <= 1'b0;
            int_id      <= 4'd0;
            int_onehot  <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            pending     <= pending_nx;
            int_valid   <= valid_nx;
            int_id      <= id_nx;
            int_onehot  <= onehot_nx;
            timeout_err <= terr_nx;
        end
    end

endmodule

// File: tb/tb_int_scheduler.sv
// Directed bench for int_scheduler (TIMEOUT=4): grant order, masking, timeout,
// ack/irq collision and asynchronous reset behaviour.
module tb_int_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] irq_in;
    logic [15:0] mask;
    logic        int_ack;
    logic        int_valid;
    logic [3:0]  int_id;
    logic [15:0] int_onehot;
    logic [15:0] pending;
    logic        timeout_err;

    int passed = 0;
    int total  = 0;

    int_scheduler #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .mask(mask),
        .int_ack(int_ack), .int_valid(int_valid), .int_id(int_id),
        .int_onehot(int_onehot), .pending(pending), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] id);
        chk({tag, "_valid"}, {15'd0, int_valid}, 16'd1);
        chk({tag, "_id"}, {12'd0, int_id}, {12'd0, id});
        chk({tag, "_onehot"}, int_onehot, 16'd1 << id);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {15'd0, int_valid}, 16'd0);
        chk({tag, "_onehot"}, int_onehot, 16'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; irq_in = 16'd0; mask = 16'd0; int_ack = 1'b0;
        tick(); tick();
        chk("rst_valid", {15'd0, int_valid}, 16'd0);
        chk("rst_id", {12'd0, int_id}, 16'd0);
        chk("rst_onehot", int_onehot, 16'd0);
        chk("rst_pending", pending, 16'd0);
        chk("rst_terr", {15'd0, timeout_err}, 16'd0);
        reset_n = 1'b1;

        // Single source
        mask = 16'hFFFF; irq_in = 16'h0001;
        tick();
        chk("single_pend", pending, 16'h0001);
        chk_idle("single_lat");
        irq_in = 16'h0000;
        tick();
        chk_grant("single_grant", 4'd0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_idle("single_ack");
        chk("single_pend_clr", pending, 16'h0000);

        // Round robin over all sources from ptr=0
        do_reset();
        irq_in = 16'hFFFF;
        tick();
        irq_in = 16'h0000;
        chk("rr_pend", pending, 16'hFFFF);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk_grant($sformatf("rr_g%0d", i), 4'(i));
            int_ack = 1'b1;
            tick();
            int_ack = 1'b0;
            chk_idle($sformatf("rr_gap%0d", i));
            tick();
        end
        chk_idle("rr_done");
        chk("rr_pend_end", pending, 16'h0000);

        // Wrap from ptr=15
        do_reset();
        irq_in = 16'h4000;
        tick();
        irq_in = 16'h0000;
        tick();
        chk_grant("wrap_g14", 4'd14);
        irq_in = 16'h8001; int_ack = 1'b1;
        tick();
        irq_in = 16'h0000; int_ack = 1'b0;
        chk("wrap_pend", pending, 16'h8001);
        tick();
        chk_grant("wrap_g15", 4'd15);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        tick();
        chk_grant("wrap_g0", 4'd0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;

        // Mask gating and grant stability under mask change
        mask = 16'hFFFE; irq_in = 16'h0001;
        tick();
        irq_in = 16'h0000;
        tick();
        chk_idle("mask_blk1");
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_idle("mask_blk2");
        chk("idle_ack_ignored", pending, 16'h0001);
        mask = 16'hFFFF;
        tick();
        chk_grant("mask_open", 4'd0);
        mask = 16'hFFFE;
        tick();
        chk_grant("mask_hold", 4'd0);
        mask = 16'hFFFF;
        int_ack = 1'b1; tick(); int_ack = 1'b0;

        // Timeout after 4 held cycles
        do_reset();
        irq_in = 16'h0003;
        tick();
        irq_in = 16'h0000;
        tick();
        chk_grant("to_c1", 4'd0);
        tick(); tick();
        chk("to_c3_terr", {15'd0, timeout_err}, 16'd0);
        tick();
        chk_grant("to_c4", 4'd0);
        tick();
        chk_idle("to_drop");
        chk("to_terr", {15'd0, timeout_err}, 16'd1);
        chk("to_pend", pending, 16'h0003);
        tick();
        chk_grant("to_next", 4'd1);
        chk("to_terr_clr", {15'd0, timeout_err}, 16'd0);
        // Ack in the expiring cycle wins over timeout
        tick(); tick(); tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_idle("ackto_drop");
        chk("ackto_terr", {15'd0, timeout_err}, 16'd0);
        chk("ackto_pend", pending, 16'h0001);
        tick();
        chk_grant("ackto_next", 4'd0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;

        // Ack/irq collision, then reset mid-grant
        do_reset();
        irq_in = 16'h0008;
        tick();
        irq_in = 16'h0000;
        tick();
        chk_grant("col_g3", 4'd3);
        irq_in = 16'h0008; int_ack = 1'b1;
        tick();
        irq_in = 16'h0000; int_ack = 1'b0;
        chk("col_pend", pending, 16'h0008);
        tick();
        chk_grant("col_regrant", 4'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("rstg");
        chk("rstg_pend", pending, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk_idle("rstg_after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
